axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Two-master, one-slave arbiter for the shared AXI4-lite read path to memory.
- Master 0 is the icache miss-fill port; master 1 is the LSU load port; the slave is the memory/SRAM read port.
- Serialises requests so that exactly one read transaction is outstanding.
- Grants by round-robin, or by fixed priority selected by parameter.

Parameters:
ADDR_W, 32, address width of all AR channels
DATA_W, 32, data width of all R channels
RR_EN, 1, 1 = round-robin grant; 0 = fixed priority, master 1 (LSU) wins

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
m0_arvalid  in  1  icache read request valid
m0_arready  out  1  icache request accepted
m0_araddr  in  ADDR_W  icache read address
m0_rvalid  out  1  icache read data valid
m0_rready  in  1  icache ready for data
m0_rdata  out  DATA_W  icache read data
m1_arvalid  in  1  LSU read request valid
m1_arready  out  1  LSU request accepted
m1_araddr  in  ADDR_W  LSU read address
m1_rvalid  out  1  LSU read data valid
m1_rready  in  1  LSU ready for data
m1_rdata  out  DATA_W  LSU read data
s_arvalid  out  1  memory read address valid
s_arready  in  1  memory accepts address
s_araddr  out  ADDR_W  memory read address
s_rvalid  in  1  memory read data valid
s_rready  out  1  memory data accepted
s_rdata  in  DATA_W  memory read data

Behaviour:
- States: IDLE, ADDR, DATA. 2-bit state register, plus registers grant_id, last_id and addr_q.
- Reset (async, rst_n=0): state=IDLE, s_arvalid=0, s_araddr=0, grant_id=0, last_id=1 (so master 0 wins first under RR). All outputs: arready=0, rvalid=0, s_rready=0, rdata=0.
- Reset mid-operation aborts the transaction. The memory slave shares rst_n, so nothing is left outstanding.
- IDLE:
  - win (combinational) = the only requester if just one arvalid is set.
  - If both are set: with RR_EN=1, win = !last_id; with RR_EN=0, win = 1.
  - mN_arready = (state==IDLE) && mN_arvalid && (win==N). It is a combinational single-cycle pulse; the loser sees arready=0.
  - On handshake: addr_q <= mN_araddr, grant_id <= N, s_arvalid <= 1, go to ADDR.
- ADDR:
  - s_araddr = addr_q, held stable.
  - s_arvalid stays 1 until s_arvalid && s_arready; then s_arvalid <= 0 and go to DATA.
  - Both mN_arready = 0.
- DATA:
  - s_rready = m[grant_id]_rready.
  - m[grant_id]_rvalid = s_rvalid and m[grant_id]_rdata = s_rdata, both combinational pass-through.
  - The non-granted master sees rvalid=0 and rdata=0.
  - On s_rvalid && s_rready: last_id <= grant_id, go to IDLE.
- Outside DATA: s_rready=0 and both mN_rvalid=0. A stray s_rvalid is ignored and must be flagged by a sim assertion.
- Latency: arvalid handshake at cycle 0; s_arvalid high at cycle 1; earliest m_rvalid at cycle 2 (s_arready at cycle 1, s_rvalid at cycle 2). Minimum 3-cycle occupancy per transaction; no overlap between transactions.
- Back-to-back: IDLE re-arbitrates in the cycle after the R handshake. A master holding arvalid cannot starve the other when RR_EN=1.
- The arbiter does not check the AXI rule that a master must hold arvalid and araddr until arready. Masters are required to comply.

Decomposition:
- Shared package axi_pkg holds:
  - the state enum {IDLE, ADDR, DATA}
  - localparams for master IDs MST_IFU=0 and MST_LSU=1
  - the default widths.
- One sub-module: rr_arb2, the combinational 2-way round-robin/fixed-priority picker (req[1:0], last_id, rr_en -> win). It is reused by the later write-channel arbiter.

Test Plan:
1. Single icache read: m0_araddr=0x8000_0000; slave gives arready at cycle 1 and rdata=0x0041_0113 at cycle 2 -> m0_arready at cycle 0, s_araddr=0x8000_0000, m0_rdata=0x0041_0113 at cycle 2, m1_rvalid stays 0.
2. Simultaneous requests, RR_EN=1: m0 at 0x8000_0010, m1 at 0xA000_0000, both held -> m0 served first, then m1. Keep both requesting for 4 transactions -> strict alternation m0,m1,m0,m1.
3. Simultaneous requests, RR_EN=0 -> m1 is served first in every contention. A later m0-only request is still served.
4. Backpressure: slave holds s_arready=0 for 5 cycles, then m1_rready=0 for 3 cycles while s_rvalid=1 -> s_arvalid and s_araddr stay stable; s_rready=0 and data is held until m1_rready rises; exactly one completion.
5. Reset mid-DATA: assert rst_n=0 asynchronously while s_rvalid=0 -> all outputs go to 0 within the same cycle; state=IDLE. After release, the first contention grants m0.
6. Stray s_rvalid=1 in IDLE -> neither mN_rvalid asserts, s_rready=0, and the assertion fires.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the memory-side read/write arbiters.
// Contents:
//   state_e      - read arbiter FSM states (IDLE, ADDR, DATA)
//   MST_IFU/LSU  - master identifiers (icache = 0, LSU = 1)
//   AXI_*_W      - default address/data widths
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way picker, shared by the read and write arbiters.
// Ports:
//   req_i[1:0]  - request from master 1 / master 0
//   last_id_i   - master that completed the previous transaction
//   rr_en_i     - 1: round-robin on contention, 0: master 1 always wins
//   win_o       - selected master (meaningful only when req_i != 0)
module rr_arb2
  import axi_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_id_i,
  input  logic       rr_en_i,
  output logic       win_o
);

  always_comb begin
    win_o = MST_IFU;
    unique case (req_i)
      2'b01:   win_o = MST_IFU;
      2'b10:   win_o = MST_LSU;
      // Contention: alternate away from the last served master, or let the LSU win.
      2'b11:   win_o = rr_en_i ? ~last_id_i : MST_LSU;
      default: win_o = MST_IFU;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master / one-slave AXI4-lite read arbiter (icache + LSU -> memory).
// Exactly one read transaction is outstanding at any time.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   m0_* (icache)         - AR: arvalid/arready/araddr, R: rvalid/rready/rdata
//   m1_* (LSU)            - same as m0
//   s_*  (memory)         - AR: arvalid/arready/araddr, R: rvalid/rready/rdata
// Parameters:
//   ADDR_W, DATA_W        - channel widths
//   RR_EN                 - 1: round-robin, 0: fixed priority with LSU winning
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int RR_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata
);

  localparam logic RR_EN_L = (RR_EN != 0);

  state_e            state_q;
  logic              grant_id_q;
  logic              last_id_q;
  logic              s_arvalid_q;
  logic [ADDR_W-1:0] addr_q;

  logic win;
  logic idle;
  logic in_data;
  logic ar_hs;

  rr_arb2 u_pick (
    .req_i     ({m1_arvalid, m0_arvalid}),
    .last_id_i (last_id_q),
    .rr_en_i   (RR_EN_L),
    .win_o     (win)
  );

  // Gate with rst_n so no arready pulse can be seen while reset is held.
  assign idle    = (state_q == IDLE) && rst_n;
  assign in_data = (state_q == DATA);

  assign m0_arready = idle && m0_arvalid && (win == MST_IFU);
  assign m1_arready = idle && m1_arvalid && (win == MST_LSU);
  assign ar_hs      = m0_arready || m1_arready;

  assign s_arvalid = s_arvalid_q;
  assign s_araddr  = addr_q;

  // R channel is a pure pass-through to the granted master, DATA state only.
  assign s_rready  = in_data && ((grant_id_q == MST_LSU) ? m1_rready : m0_rready);
  assign m0_rvalid = in_data && (grant_id_q == MST_IFU) && s_rvalid;
  assign m1_rvalid = in_data && (grant_id_q == MST_LSU) && s_rvalid;
  assign m0_rdata  = (in_data && (grant_id_q == MST_IFU)) ? s_rdata : '0;
  assign m1_rdata  = (in_data && (grant_id_q == MST_LSU)) ? s_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_id_q  <= MST_IFU;
      // last_id = LSU makes the icache win the first contention under round-robin.
      last_id_q   <= MST_LSU;
      s_arvalid_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ar_hs) begin
            addr_q      <= (win == MST_LSU) ? m1_araddr : m0_araddr;
            grant_id_q  <= win;
            s_arvalid_q <= 1'b1;
            state_q     <= ADDR;
          end
        end
        ADDR: begin
          if (s_arvalid_q && s_arready) begin
            s_arvalid_q <= 1'b0;
            state_q     <= DATA;
          end
        end
        DATA: begin
          if (s_rvalid && s_rready) begin
            last_id_q <= grant_id_q;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data arriving with no transaction in its data phase is dropped; flag it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (in_data || !s_rvalid)
        else $warning("axi_rd_arbiter: stray s_rvalid outside data phase ignored");
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter. Two instances share all inputs:
// r_* is round-robin (RR_EN=1), f_* is fixed priority (RR_EN=0). Slave
// timing is independent of the grant, so both walk the same state sequence.
module tb_axi_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_arvalid, m0_rready, m1_arvalid, m1_rready;
  logic [AW-1:0] m0_araddr, m1_araddr;
  logic          s_arready, s_rvalid;
  logic [DW-1:0] s_rdata;

  logic          r_m0_arready, r_m0_rvalid, r_m1_arready, r_m1_rvalid;
  logic [DW-1:0] r_m0_rdata, r_m1_rdata;
  logic          r_s_arvalid, r_s_rready;
  logic [AW-1:0] r_s_araddr;
  logic          f_m0_arready, f_m0_rvalid, f_m1_arready, f_m1_rvalid;
  logic [DW-1:0] f_m0_rdata, f_m1_rdata;
  logic          f_s_arvalid, f_s_rready;
  logic [AW-1:0] f_s_araddr;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m0_arvalid), .m0_arready(r_m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(r_m0_rvalid), .m0_rready(m0_rready), .m0_rdata(r_m0_rdata),
    .m1_arvalid(m1_arvalid), .m1_arready(r_m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(r_m1_rvalid), .m1_rready(m1_rready), .m1_rdata(r_m1_rdata),
    .s_arvalid(r_s_arvalid), .s_arready(s_arready), .s_araddr(r_s_araddr),
    .s_rvalid(s_rvalid), .s_rready(r_s_rready), .s_rdata(s_rdata)
  );

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m0_arvalid), .m0_arready(f_m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(f_m0_rvalid), .m0_rready(m0_rready), .m0_rdata(f_m0_rdata),
    .m1_arvalid(m1_arvalid), .m1_arready(f_m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(f_m1_rvalid), .m1_rready(m1_rready), .m1_rdata(f_m1_rdata),
    .s_arvalid(f_s_arvalid), .s_arready(s_arready), .s_araddr(f_s_araddr),
    .s_rvalid(s_rvalid), .s_rready(f_s_rready), .s_rdata(s_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with arready at cycle 1 and rdata at cycle 2.
  // Entered and left at posedge+1 with the arbiters in IDLE.
  // rw/fw: master expected to win in the RR / fixed-priority instance.
  task automatic txn(input string tag, input logic v0, input logic v1,
                     input logic rw, input logic fw, input logic [31:0] d);
    logic [31:0] r_addr, f_addr;
    r_addr = rw ? m1_araddr : m0_araddr;
    f_addr = fw ? m1_araddr : m0_araddr;
    m0_arvalid = v0; m1_arvalid = v1; m0_rready = 1'b1; m1_rready = 1'b1;
    #1;
    chk({tag, ".r_m0_arready"}, r_m0_arready, v0 && !rw);
    chk({tag, ".r_m1_arready"}, r_m1_arready, v1 && rw);
    chk({tag, ".f_m0_arready"}, f_m0_arready, v0 && !fw);
    chk({tag, ".f_m1_arready"}, f_m1_arready, v1 && fw);
    tick();
    s_arready = 1'b1;
    #1;
    chk({tag, ".r_s_arvalid"}, r_s_arvalid, 1'b1);
    chk({tag, ".r_s_araddr"}, r_s_araddr, r_addr);
    chk({tag, ".f_s_araddr"}, f_s_araddr, f_addr);
    chk({tag, ".r_arready_busy"}, {r_m1_arready, r_m0_arready}, 2'b00);
    tick();
    s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = d;
    #1;
    chk({tag, ".r_s_arvalid_lo"}, r_s_arvalid, 1'b0);
    chk({tag, ".r_rvalid"}, {r_m1_rvalid, r_m0_rvalid}, rw ? 2'b10 : 2'b01);
    chk({tag, ".r_rdata_win"}, rw ? r_m1_rdata : r_m0_rdata, d);
    chk({tag, ".r_rdata_lose"}, rw ? r_m0_rdata : r_m1_rdata, 32'h0);
    chk({tag, ".r_s_rready"}, r_s_rready, 1'b1);
    chk({tag, ".f_rvalid"}, {f_m1_rvalid, f_m0_rvalid}, fw ? 2'b10 : 2'b01);
    chk({tag, ".f_rdata_win"}, fw ? f_m1_rdata : f_m0_rdata, d);
    tick();
    s_rvalid = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    m0_araddr = '0; m1_araddr = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.s_arvalid", r_s_arvalid, 1'b0);
    chk("rst.s_araddr", r_s_araddr, 32'h0);
    chk("rst.s_rready", r_s_rready, 1'b0);
    chk("rst.rvalid", {r_m1_rvalid, r_m0_rvalid}, 2'b00);
    chk("rst.rdata", r_m0_rdata | r_m1_rdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // 1: single icache read
    m0_araddr = 32'h8000_0000;
    txn("t1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0041_0113);
    m0_arvalid = 1'b0;
    #1;
    chk("t1.idle_s_arvalid", r_s_arvalid, 1'b0);
    chk("t1.idle_rvalid", {r_m1_rvalid, r_m0_rvalid}, 2'b00);

    // 2/3: both held; RR alternates starting with m0, fixed priority always m1
    do_reset();
    m0_araddr = 32'h8000_0010; m1_araddr = 32'hA000_0000;
    txn("t2a", 1'b1, 1'b1, 1'b0, 1'b1, 32'h1111_0001);
    txn("t2b", 1'b1, 1'b1, 1'b1, 1'b1, 32'h1111_0002);
    txn("t2c", 1'b1, 1'b1, 1'b0, 1'b1, 32'h1111_0003);
    txn("t2d", 1'b1, 1'b1, 1'b1, 1'b1, 32'h1111_0004);
    txn("t3", 1'b1, 1'b0, 1'b0, 1'b0, 32'h2222_0005);
    m0_arvalid = 1'b0;

    // 4: backpressure on AR then on R, LSU only
    m1_araddr = 32'hA000_0040; m1_arvalid = 1'b1; m1_rready = 1'b1;
    #1;
    chk("t4.arready", r_m1_arready, 1'b1);
    tick();
    m1_arvalid = 1'b0; m1_araddr = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4.s_arvalid_hold", r_s_arvalid, 1'b1);
      chk("t4.s_araddr_hold", r_s_araddr, 32'hA000_0040);
      tick();
    end
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h3333_0006; m1_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4.s_rready_lo", r_s_rready, 1'b0);
      chk("t4.m1_rvalid_hold", r_m1_rvalid, 1'b1);
      chk("t4.m1_rdata_hold", r_m1_rdata, 32'h3333_0006);
      tick();
    end
    m1_rready = 1'b1;
    #1;
    chk("t4.s_rready_hi", r_s_rready, 1'b1);
    tick();
    s_rvalid = 1'b0;
    #1;
    chk("t4.done_rvalid", r_m1_rvalid, 1'b0);
    chk("t4.done_s_arvalid", r_s_arvalid, 1'b0);

    // 5: reset while in DATA with s_rvalid low; last served becomes m0 first
    m0_araddr = 32'h8000_0020;
    txn("t5pre", 1'b1, 1'b0, 1'b0, 1'b0, 32'h4444_0007);
    m0_araddr = 32'h8000_0030;
    m0_arvalid = 1'b1;
    tick();
    m0_arvalid = 1'b0; s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    #1;
    chk("t5.pre_s_rready", r_s_rready, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5.rst_s_rready", r_s_rready, 1'b0);
    chk("t5.rst_s_arvalid", r_s_arvalid, 1'b0);
    chk("t5.rst_s_araddr", r_s_araddr, 32'h0);
    chk("t5.rst_rvalid", {r_m1_rvalid, r_m0_rvalid}, 2'b00);
    @(negedge clk) rst_n = 1'b1;
    tick();
    m0_araddr = 32'h8000_0040; m1_araddr = 32'hA000_0080;
    txn("t5post", 1'b1, 1'b1, 1'b0, 1'b1, 32'h5555_0008);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;

    // 6: stray read data while idle is ignored
    s_rvalid = 1'b1; s_rdata = 32'h6666_0009;
    #1;
    chk("t6.r_rvalid", {r_m1_rvalid, r_m0_rvalid}, 2'b00);
    chk("t6.r_s_rready", r_s_rready, 1'b0);
    chk("t6.f_rvalid", {f_m1_rvalid, f_m0_rvalid}, 2'b00);
    chk("t6.r_rdata", r_m0_rdata | r_m1_rdata, 32'h0);
    tick();
    s_rvalid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
